// File: rtl/beta_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request and a single-entry output buffer.
// Optional macro BETA_FETCH_MISALIGN_CHECK_EN halts on misaligned redirect targets.
module beta_fetch_unit #(
  parameter int unsigned              DataWidth = 32,
  parameter logic [DataWidth-1:0]     BootAddr  = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 imem_req_o,
  output logic [DataWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  input  logic                 redirect_i,
  input  logic [DataWidth-1:0] redirect_pc_i,
  input  logic                 pip_stall_i,
  output logic [DataWidth-1:0] pip_instr_o,
  output logic                 pip_new_instr_o,
  output logic [DataWidth-1:0] pip_next_pc_o,
  output logic                 fetch_misalign_o
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;
`ifdef BETA_FETCH_MISALIGN_CHECK_EN
  localparam logic [1:0] S_HALT  = 2'd3;
`endif

  localparam logic [DataWidth-1:0] AlignMask = ~(DataWidth'(3));
  localparam logic [DataWidth-1:0] PcStep    = DataWidth'(4);

  logic [1:0]           state_q, state_d;
  logic [DataWidth-1:0] pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] instr_q, instr_d;
  logic [DataWidth-1:0] next_pc_q, next_pc_d;
  logic [DataWidth-1:0] pc_inc_s;
  logic [DataWidth-1:0] redir_pc_s;
  logic                 req_s;
`ifdef BETA_FETCH_MISALIGN_CHECK_EN
  logic                 halt_pend_q, halt_pend_d;
  logic                 redir_bad_s;
`endif

  always_comb begin
    pc_inc_s  = pc_q + PcStep;
    req_s     = 1'b0;
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    next_pc_d = next_pc_q;
`ifdef BETA_FETCH_MISALIGN_CHECK_EN
    halt_pend_d = halt_pend_q;
    redir_bad_s = (redirect_pc_i[1:0] != 2'b00);
    redir_pc_s  = redirect_pc_i;
`else
    redir_pc_s  = redirect_pc_i & AlignMask;
`endif

    // A new request may only go out when the buffer is free or drains this cycle.
    if (!rst_i && (state_q == S_FETCH)) begin
      req_s = ~valid_q | ~pip_stall_i;
    end else begin
      req_s = 1'b0;
    end

    if (valid_q && !pip_stall_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      S_FETCH: begin
        if (req_s && imem_gnt_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          instr_d   = imem_rdata_i;
          next_pc_d = pc_inc_s;
          pc_d      = pc_inc_s;
          valid_d   = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d   = S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) begin
`ifdef BETA_FETCH_MISALIGN_CHECK_EN
          state_d = halt_pend_q ? S_HALT : S_FETCH;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_DROP;
        end
      end
`ifdef BETA_FETCH_MISALIGN_CHECK_EN
      S_HALT: begin
        valid_d = 1'b0;
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Redirect overrides everything; a granted or pending response must still be drained.
    if (redirect_i) begin
      pc_d    = redir_pc_s;
      valid_d = 1'b0;
      case (state_q)
        S_FETCH: state_d = (req_s && imem_gnt_i) ? S_DROP : S_FETCH;
        S_WAIT:  state_d = imem_rvalid_i ? S_FETCH : S_DROP;
        S_DROP:  state_d = imem_rvalid_i ? S_FETCH : S_DROP;
        default: state_d = S_FETCH;
      endcase
`ifdef BETA_FETCH_MISALIGN_CHECK_EN
      if (state_d == S_DROP) begin
        halt_pend_d = redir_bad_s;
      end else if (redir_bad_s) begin
        state_d = S_HALT;
      end else begin
        state_d = S_FETCH;
      end
`endif
    end else begin
      pc_d = pc_d;
    end

`ifdef BETA_FETCH_MISALIGN_CHECK_EN
    if (state_d != S_DROP) begin
      halt_pend_d = 1'b0;
    end else begin
      halt_pend_d = halt_pend_d;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      pc_q      <= BootAddr;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      next_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      next_pc_q <= next_pc_d;
    end
  end

`ifdef BETA_FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      halt_pend_q <= 1'b0;
    end else begin
      halt_pend_q <= halt_pend_d;
    end
  end

  assign fetch_misalign_o = (state_q == S_HALT);
`else
  assign fetch_misalign_o = 1'b0;
`endif

  assign imem_req_o      = req_s;
  assign imem_addr_o     = pc_q;
  assign pip_instr_o     = instr_q;
  assign pip_new_instr_o = valid_q;
  assign pip_next_pc_o   = next_pc_q;

endmodule

// File: tb/tb_beta_fetch_unit.sv
// Self-checking bench for beta_fetch_unit: directed scenarios, then a randomized
// memory/stall/redirect run checked against an in-order instruction stream model.
module tb_beta_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        pip_stall_i;
  logic [31:0] pip_instr_o;
  logic        pip_new_instr_o;
  logic [31:0] pip_next_pc_o;
  logic        fetch_misalign_o;

  int total = 0;
  int bad   = 0;

  beta_fetch_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .pip_stall_i     (pip_stall_i),
    .pip_instr_o     (pip_instr_o),
    .pip_new_instr_o (pip_new_instr_o),
    .pip_next_pc_o   (pip_next_pc_o),
    .fetch_misalign_o(fetch_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Memory content: a distinct word per address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_00FF;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req_o},       32'd0);
    chk({tag, "_addr"},  imem_addr_o,               32'h0000_0000);
    chk({tag, "_v"},     {31'd0, pip_new_instr_o},  32'd0);
    chk({tag, "_instr"}, pip_instr_o,               32'd0);
    chk({tag, "_npc"},   pip_next_pc_o,             32'd0);
    chk({tag, "_mis"},   {31'd0, fetch_misalign_o}, 32'd0);
  endtask

  // Random-phase model state
  logic [31:0] expect_pc;
  logic        outstanding;
  logic [31:0] out_addr;
  int          delay;
  logic        hold_chk;
  logic [31:0] held_instr, held_npc;
  logic        do_redir;
  logic [31:0] tgt;
  int          consumed_cnt;

  initial begin
    rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    redirect_i = 1'b0; redirect_pc_i = 32'd0; pip_stall_i = 1'b0;
    #2;
    chk_reset_state("rst_async");
    tick(); tick();
    chk_reset_state("rst_held");

    // Reset release: request to BootAddr immediately, one-cycle response
    rst_i = 1'b0; #1;
    chk("rel_req",  {31'd0, imem_req_o}, 32'd1);
    chk("rel_addr", imem_addr_o, 32'h0000_0000);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013; #1;
    chk("wait_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b0; #1;
    chk("first_instr", pip_instr_o, 32'h0000_0013);
    chk("first_npc",   pip_next_pc_o, 32'h0000_0004);
    chk("first_v",     {31'd0, pip_new_instr_o}, 32'd1);
    chk("first_next_req",  {31'd0, imem_req_o}, 32'd1);
    chk("first_next_addr", imem_addr_o, 32'h0000_0004);

    // Stall for 5 cycles: outputs frozen, no request
    pip_stall_i = 1'b1; #1;
    chk("stall_req0", {31'd0, imem_req_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_instr", pip_instr_o, 32'h0000_0013);
      chk("stall_npc",   pip_next_pc_o, 32'h0000_0004);
      chk("stall_v",     {31'd0, pip_new_instr_o}, 32'd1);
      chk("stall_req",   {31'd0, imem_req_o}, 32'd0);
    end
    tick();
    pip_stall_i = 1'b0; #1;
    chk("unstall_req",  {31'd0, imem_req_o}, 32'd1);
    chk("unstall_addr", imem_addr_o, 32'h0000_0004);
    imem_gnt_i = 1'b1;
    tick();

    // Redirect while waiting; the stale response two cycles later is dropped
    imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    tick();
    redirect_i = 1'b0;
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; #1;
    chk("drop_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b0; #1;
    chk("drop_v",     {31'd0, pip_new_instr_o}, 32'd0);
    chk("drop_stale", {31'd0, pip_instr_o === 32'hDEAD_BEEF}, 32'd0);
    chk("drop_req1",  {31'd0, imem_req_o}, 32'd1);
    chk("drop_addr",  imem_addr_o, 32'h0000_0100);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0ABC;
    tick();
    imem_rvalid_i = 1'b0; #1;
    chk("redir_instr", pip_instr_o, 32'h0000_0ABC);
    chk("redir_npc",   pip_next_pc_o, 32'h0000_0104);

    // PC wrap at the top of the address space
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0; #1;
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap_req",  {31'd0, imem_req_o}, 32'd1);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0067;
    tick();
    imem_rvalid_i = 1'b0; #1;
    chk("wrap_npc",   pip_next_pc_o, 32'h0000_0000);
    chk("wrap_instr", pip_instr_o, 32'h0000_0067);
    chk("wrap_next",  imem_addr_o, 32'h0000_0000);

    // Misaligned redirect
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
    tick();
    redirect_i = 1'b0; #1;
`ifdef BETA_FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      chk("mis_flag", {31'd0, fetch_misalign_o}, 32'd1);
      chk("mis_req",  {31'd0, imem_req_o}, 32'd0);
      chk("mis_v",    {31'd0, pip_new_instr_o}, 32'd0);
      tick();
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    tick();
    redirect_i = 1'b0; #1;
    chk("mis_exit_flag", {31'd0, fetch_misalign_o}, 32'd0);
    chk("mis_exit_req",  {31'd0, imem_req_o}, 32'd1);
    chk("mis_exit_addr", imem_addr_o, 32'h0000_0200);
`else
    chk("align_addr", imem_addr_o, 32'h0000_0100);
    chk("align_req",  {31'd0, imem_req_o}, 32'd1);
    chk("align_mis",  {31'd0, fetch_misalign_o}, 32'd0);
`endif

    // Reset with a request outstanding; late response after release is ignored
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; rst_i = 1'b1; #1;
    chk_reset_state("rst_mid");
    tick();
    rst_i = 1'b0; #1;
    chk("rel2_req",  {31'd0, imem_req_o}, 32'd1);
    chk("rel2_addr", imem_addr_o, 32'h0000_0000);
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0BAD;
    tick();
    imem_rvalid_i = 1'b0; #1;
    chk("late_v",    {31'd0, pip_new_instr_o}, 32'd0);
    chk("late_req",  {31'd0, imem_req_o}, 32'd1);
    chk("late_addr", imem_addr_o, 32'h0000_0000);

    // Randomized run against the in-order stream model
    rst_i = 1'b1; tick(); tick();
    rst_i = 1'b0;
    expect_pc = 32'h0000_0000; outstanding = 1'b0; out_addr = 32'd0; delay = 0;
    hold_chk = 1'b0; held_instr = 32'd0; held_npc = 32'd0; consumed_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      pip_stall_i = ($urandom_range(0, 3) == 0);
      imem_gnt_i  = ($urandom_range(0, 2) != 0);
      do_redir    = ($urandom_range(0, 19) == 0);
      tgt         = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom_range(0, 3) * 4))
                                               : ($urandom_range(0, 1023) * 4);
      redirect_i    = do_redir;
      redirect_pc_i = tgt;
      if (outstanding && delay == 0) begin
        imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(out_addr);
      end else begin
        imem_rvalid_i = 1'b0; imem_rdata_i = $urandom();
      end
      #1;
      if (hold_chk) begin
        chk("rnd_hold_v",     {31'd0, pip_new_instr_o}, 32'd1);
        chk("rnd_hold_instr", pip_instr_o, held_instr);
        chk("rnd_hold_npc",   pip_next_pc_o, held_npc);
      end
      if (pip_new_instr_o && pip_stall_i) chk("rnd_stall_req", {31'd0, imem_req_o}, 32'd0);
      if (outstanding) chk("rnd_one_outstanding", {31'd0, imem_req_o}, 32'd0);
      if (pip_new_instr_o && !pip_stall_i) begin
        chk("rnd_instr", pip_instr_o, mem_word(expect_pc));
        chk("rnd_npc",   pip_next_pc_o, expect_pc + 32'd4);
        expect_pc = expect_pc + 32'd4;
        consumed_cnt++;
      end
      hold_chk   = pip_new_instr_o && pip_stall_i && !do_redir;
      held_instr = pip_instr_o;
      held_npc   = pip_next_pc_o;
      if (do_redir) expect_pc = tgt;
      if (imem_rvalid_i) outstanding = 1'b0;
      else if (outstanding) delay--;
      if (imem_req_o && imem_gnt_i) begin
        outstanding = 1'b1; out_addr = imem_addr_o; delay = $urandom_range(0, 2);
      end
      tick();
    end
    chk("rnd_progress", {31'd0, consumed_cnt > 50}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
